// File: rtl/cam_rotate_writer.sv
// Rotates a 320x240 raster camera stream 90 degrees into a 240x320 portrait frame buffer.
// Define CAM_ROTATE_WRITER_CCW_EN for counter-clockwise rotation (default build: clockwise).
module cam_rotate_writer #(
  parameter int H_IN    = 320,
  parameter int V_IN    = 240,
  parameter int PIXEL_W = 16,
  parameter int ADDR_W  = 17
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_pixel_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               frame_done_in,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic [ADDR_W-1:0]  pixel_addr_out,
  output logic               valid_pixel_out,
  output logic               frame_done_out,
  output logic               frame_error_out,
  output logic [1:0]         state_dbg
);

  // Handshake: there is no back-pressure. A pixel is taken on every cycle with
  // valid_pixel_in=1 unless frame_done_in is also high or the FSM is not ACTIVE;
  // valid_pixel_out is a single-cycle write strobe one cycle after an accepted pixel.

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam logic [8:0]        COL_LAST = 9'(H_IN - 1);
  localparam logic [7:0]        ROW_LAST = 8'(V_IN - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(V_IN);
`ifdef CAM_ROTATE_WRITER_CCW_EN
  localparam logic [ADDR_W-1:0] ROW0_BASE = ADDR_W'(V_IN * (H_IN - 1));
`else
  localparam logic [ADDR_W-1:0] ROW0_BASE = ADDR_W'(V_IN - 1);
`endif

  state_t            state, state_d;
  logic [8:0]        col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_base_nxt;
  logic [ADDR_W-1:0] addr_step;
  logic              dropped;

  logic last_pixel;
  logic accept;
  logic reload;
  logic done_pulse;
  logic err_pulse;
  logic drop_set;

  assign state_dbg  = state;
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

`ifdef CAM_ROTATE_WRITER_CCW_EN
  assign row_base_nxt = row_base + 1'b1;
  assign addr_step    = addr - STEP;
`else
  assign row_base_nxt = row_base - 1'b1;
  assign addr_step    = addr + STEP;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= SYNC;
    else        state <= state_d;
  end

  // frame_done_in takes priority over a coincident pixel in every state.
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    reload     = 1'b0;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    drop_set   = 1'b0;
    case (state)
      SYNC: begin
        if (frame_done_in) begin
          reload  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_done_in) begin
          err_pulse = 1'b1;
          reload    = 1'b1;
        end else if (valid_pixel_in) begin
          accept = 1'b1;
          if (last_pixel) state_d = FULL;
        end
      end
      FULL: begin
        if (frame_done_in) begin
          done_pulse = ~dropped;
          reload     = 1'b1;
          state_d    = ACTIVE;
        end else if (valid_pixel_in && !dropped) begin
          err_pulse = 1'b1;
          drop_set  = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out       <= '0;
      pixel_addr_out  <= '0;
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      col             <= '0;
      row             <= '0;
      addr            <= '0;
      row_base        <= '0;
      dropped         <= 1'b0;
    end else begin
      valid_pixel_out <= accept;
      frame_done_out  <= done_pulse;
      frame_error_out <= err_pulse;
      if (accept) begin
        pixel_out      <= pixel_in;
        pixel_addr_out <= addr;
      end
      if (reload) begin
        col      <= '0;
        row      <= '0;
        addr     <= ROW0_BASE;
        row_base <= ROW0_BASE;
        dropped  <= 1'b0;
      end else begin
        // The final pixel leaves the counters alone so row_base never wraps past the frame.
        if (accept && !last_pixel) begin
          if (col == COL_LAST) begin
            col      <= '0;
            row      <= row + 1'b1;
            row_base <= row_base_nxt;
            addr     <= row_base_nxt;
          end else begin
            col  <= col + 1'b1;
            addr <= addr_step;
          end
        end
        if (drop_set) dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_rotate_writer.sv
// Directed self-checking bench for cam_rotate_writer: a full-size instance for the
// address mapping and frame tracking, plus a small 8x4 instance for the overflow case.
module tb_cam_rotate_writer;

`ifdef CAM_ROTATE_WRITER_CCW_EN
  localparam int E_FIRST  = 76560;
  localparam int E_SECOND = 76320;
  localparam int E_THIRD  = 76080;
  localparam int E_R0_END = 0;
  localparam int E_R1_BEG = 76561;
  localparam int E_LAST   = 239;
  localparam int S_LAST   = 3;
  localparam int S_FIRST  = 28;
`else
  localparam int E_FIRST  = 239;
  localparam int E_SECOND = 479;
  localparam int E_THIRD  = 719;
  localparam int E_R0_END = 76799;
  localparam int E_R1_BEG = 238;
  localparam int E_LAST   = 76560;
  localparam int S_LAST   = 28;
  localparam int S_FIRST  = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  // ---------------- full-size DUT ----------------
  logic        valid_pixel_in = 1'b0;
  logic [15:0] pixel_in = '0;
  logic        frame_done_in = 1'b0;
  logic [15:0] pixel_out;
  logic [16:0] pixel_addr_out;
  logic        valid_pixel_out;
  logic        frame_done_out;
  logic        frame_error_out;
  logic [1:0]  state_dbg;

  cam_rotate_writer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .valid_pixel_in  (valid_pixel_in),
    .pixel_in        (pixel_in),
    .frame_done_in   (frame_done_in),
    .pixel_out       (pixel_out),
    .pixel_addr_out  (pixel_addr_out),
    .valid_pixel_out (valid_pixel_out),
    .frame_done_out  (frame_done_out),
    .frame_error_out (frame_error_out),
    .state_dbg       (state_dbg)
  );

  // ---------------- small DUT (8 columns x 4 rows) ----------------
  logic        s_valid_in = 1'b0;
  logic [15:0] s_pixel_in = '0;
  logic        s_fd_in = 1'b0;
  logic [15:0] s_pixel_out;
  logic [4:0]  s_addr_out;
  logic        s_valid_out;
  logic        s_done_out;
  logic        s_err_out;
  logic [1:0]  s_state_dbg;

  cam_rotate_writer #(.H_IN(8), .V_IN(4), .PIXEL_W(16), .ADDR_W(5)) dut_s (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .valid_pixel_in  (s_valid_in),
    .pixel_in        (s_pixel_in),
    .frame_done_in   (s_fd_in),
    .pixel_out       (s_pixel_out),
    .pixel_addr_out  (s_addr_out),
    .valid_pixel_out (s_valid_out),
    .frame_done_out  (s_done_out),
    .frame_error_out (s_err_out),
    .state_dbg       (s_state_dbg)
  );

  // ---------------- write capture ----------------
  logic [16:0] waddr_q[$];
  logic [15:0] wpix_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [4:0]  s_waddr_q[$];
  int          s_done_cnt = 0;
  int          s_err_cnt  = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  always @(negedge clk_in) begin
    if (valid_pixel_out) begin
      waddr_q.push_back(pixel_addr_out);
      wpix_q.push_back(pixel_out);
    end
    if (frame_done_out)  done_cnt++;
    if (frame_error_out) err_cnt++;
    if (s_valid_out) s_waddr_q.push_back(s_addr_out);
    if (s_done_out)  s_done_cnt++;
    if (s_err_out)   s_err_cnt++;
  end

  function automatic logic [15:0] pix_of(input int i);
    return 16'(i) ^ 16'h5A3C;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [15:0] p, input logic fd);
    @(negedge clk_in);
    valid_pixel_in = v;
    pixel_in       = p;
    frame_done_in  = fd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0);
  endtask

  task automatic s_drive(input logic v, input logic [15:0] p, input logic fd);
    @(negedge clk_in);
    s_valid_in = v;
    s_pixel_in = p;
    s_fd_in    = fd;
  endtask

  task automatic clear_capture();
    waddr_q.delete();
    wpix_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    tests_run++;
    if (valid_pixel_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_pixel_out);
    end
    tests_run++;
    if (pixel_out !== 16'h0 || pixel_addr_out !== 17'h0) begin
      tests_failed++; $display("FAIL reset_data: got pix %h addr %0d want 0/0", pixel_out, pixel_addr_out);
    end
    tests_run++;
    if (frame_done_out !== 1'b0 || frame_error_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got done %b err %b want 0/0", frame_done_out, frame_error_out);
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d want 0 (SYNC)", state_dbg);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_sync_then_first_pixels();
    int exp_a[3];
    exp_a[0] = E_FIRST; exp_a[1] = E_SECOND; exp_a[2] = E_THIRD;
    clear_capture();
    for (int i = 0; i < 5; i++) drive(1'b1, 16'hBEEF, 1'b0);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 0) begin
      tests_failed++; $display("FAIL sync_discard: got %0d writes want 0", waddr_q.size());
    end
    drive(1'b0, 16'h0, 1'b1);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, pix_of(k), 1'b0);
      tests_run++;
      if (valid_pixel_out !== 1'b0) begin
        tests_failed++; $display("FAIL early_valid_%0d: got %b want 0", k, valid_pixel_out);
      end
      idle(1);
      tests_run++;
      if (valid_pixel_out !== 1'b1 || pixel_addr_out !== 17'(exp_a[k]) || pixel_out !== pix_of(k)) begin
        tests_failed++;
        $display("FAIL first_pixel_%0d: got v %b addr %0d pix %h want 1 %0d %h",
                 k, valid_pixel_out, pixel_addr_out, pixel_out, exp_a[k], pix_of(k));
      end
    end
    idle(1);
    tests_run++;
    if (valid_pixel_out !== 1'b0 || pixel_addr_out !== 17'(E_THIRD)) begin
      tests_failed++; $display("FAIL hold_outputs: got v %b addr %0d want 0 %0d", valid_pixel_out, pixel_addr_out, E_THIRD);
    end
  endtask

  task automatic test_full_frame();
    drive(1'b0, 16'h0, 1'b1);
    idle(2);
    clear_capture();
    for (int i = 0; i < 76800; i++) drive(1'b1, pix_of(i), 1'b0);
    idle(2);
    tests_run++;
    if (state_dbg !== 2'd2) begin
      tests_failed++; $display("FAIL full_state: got %0d want 2 (FULL)", state_dbg);
    end
    drive(1'b0, 16'h0, 1'b1);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 76800) begin
      tests_failed++; $display("FAIL full_count: got %0d writes want 76800", waddr_q.size());
    end else begin
      tests_run++;
      if (waddr_q[0] !== 17'(E_FIRST) || waddr_q[1] !== 17'(E_SECOND)) begin
        tests_failed++; $display("FAIL full_first: got %0d %0d want %0d %0d", waddr_q[0], waddr_q[1], E_FIRST, E_SECOND);
      end
      tests_run++;
      if (waddr_q[319] !== 17'(E_R0_END)) begin
        tests_failed++; $display("FAIL addr_r0_c319: got %0d want %0d", waddr_q[319], E_R0_END);
      end
      tests_run++;
      if (waddr_q[320] !== 17'(E_R1_BEG) || wpix_q[320] !== pix_of(320)) begin
        tests_failed++; $display("FAIL addr_r1_c0: got %0d pix %h want %0d %h", waddr_q[320], wpix_q[320], E_R1_BEG, pix_of(320));
      end
      tests_run++;
      if (waddr_q[76799] !== 17'(E_LAST) || wpix_q[76799] !== pix_of(76799)) begin
        tests_failed++; $display("FAIL addr_last: got %0d pix %h want %0d %h", waddr_q[76799], wpix_q[76799], E_LAST, pix_of(76799));
      end
    end
    tests_run++;
    if (done_cnt != 1 || err_cnt != 0) begin
      tests_failed++; $display("FAIL full_pulses: got done %0d err %0d want 1 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_short_frame();
    clear_capture();
    for (int i = 0; i < 100; i++) drive(1'b1, pix_of(i), 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    idle(3);
    tests_run++;
    if (err_cnt != 1 || done_cnt != 0) begin
      tests_failed++; $display("FAIL short_pulses: got err %0d done %0d want 1 0", err_cnt, done_cnt);
    end
    drive(1'b1, 16'h1234, 1'b0);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 101 || waddr_q[waddr_q.size()-1] !== 17'(E_FIRST)) begin
      tests_failed++; $display("FAIL short_restart: got %0d writes last addr %0d want 101 %0d",
                               waddr_q.size(), waddr_q[waddr_q.size()-1], E_FIRST);
    end
  endtask

  task automatic test_coincident_done();
    clear_capture();
    drive(1'b1, 16'hDEAD, 1'b1);
    drive(1'b1, 16'h7777, 1'b0);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 1 || waddr_q[0] !== 17'(E_FIRST) || wpix_q[0] !== 16'h7777) begin
      tests_failed++; $display("FAIL coincident: got %0d writes addr %0d pix %h want 1 %0d 7777",
                               waddr_q.size(), waddr_q[0], wpix_q[0], E_FIRST);
    end
    tests_run++;
    if (err_cnt != 1) begin
      tests_failed++; $display("FAIL coincident_err: got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    tests_run++;
    if (valid_pixel_out !== 1'b0 || pixel_out !== 16'h0 || pixel_addr_out !== 17'h0 ||
        frame_done_out !== 1'b0 || frame_error_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_outputs: got v %b pix %h addr %0d done %b err %b want all 0",
                               valid_pixel_out, pixel_out, pixel_addr_out, frame_done_out, frame_error_out);
    end
    valid_pixel_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    clear_capture();
    for (int i = 0; i < 6; i++) drive(1'b1, pix_of(i), 1'b0);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 0 || state_dbg !== 2'd0) begin
      tests_failed++; $display("FAIL reset_mid_sync: got %0d writes state %0d want 0 0", waddr_q.size(), state_dbg);
    end
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b1, 16'h3333, 1'b0);
    idle(3);
    tests_run++;
    if (waddr_q.size() != 1 || waddr_q[0] !== 17'(E_FIRST)) begin
      tests_failed++; $display("FAIL reset_mid_resume: got %0d writes addr %0d want 1 %0d", waddr_q.size(), waddr_q[0], E_FIRST);
    end
  endtask

  task automatic test_overflow();
    s_drive(1'b0, 16'h0, 1'b1);
    s_drive(1'b0, 16'h0, 1'b0);
    s_waddr_q.delete();
    s_done_cnt = 0;
    s_err_cnt  = 0;
    for (int i = 0; i < 34; i++) s_drive(1'b1, pix_of(i), 1'b0);
    s_drive(1'b0, 16'h0, 1'b0);
    s_drive(1'b0, 16'h0, 1'b1);
    s_drive(1'b0, 16'h0, 1'b0);
    repeat (3) @(negedge clk_in);
    tests_run++;
    if (s_waddr_q.size() != 32) begin
      tests_failed++; $display("FAIL overflow_count: got %0d writes want 32", s_waddr_q.size());
    end else begin
      tests_run++;
      if (s_waddr_q[0] !== 5'(S_FIRST) || s_waddr_q[31] !== 5'(S_LAST)) begin
        tests_failed++; $display("FAIL overflow_addrs: got %0d %0d want %0d %0d", s_waddr_q[0], s_waddr_q[31], S_FIRST, S_LAST);
      end
    end
    tests_run++;
    if (s_err_cnt != 1 || s_done_cnt != 0) begin
      tests_failed++; $display("FAIL overflow_pulses: got err %0d done %0d want 1 0", s_err_cnt, s_done_cnt);
    end
    s_done_cnt = 0;
    s_err_cnt  = 0;
    for (int i = 0; i < 32; i++) s_drive(1'b1, pix_of(i), 1'b0);
    s_drive(1'b0, 16'h0, 1'b1);
    s_drive(1'b0, 16'h0, 1'b0);
    repeat (3) @(negedge clk_in);
    tests_run++;
    if (s_done_cnt != 1 || s_err_cnt != 0) begin
      tests_failed++; $display("FAIL small_exact_frame: got done %0d err %0d want 1 0", s_done_cnt, s_err_cnt);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_sync_then_first_pixels();
    test_full_frame();
    test_short_frame();
    test_coincident_done();
    test_reset_mid_frame();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cam_rotate_writer.md
# cam_rotate_writer

Write-side counterpart to the display-side rotated-address reader. Accepts the camera's raster pixel stream: 320 columns × 240 rows, row-major, one `valid_pixel_in` per pixel. Rotates each pixel 90° clockwise into a 240-wide × 320-tall portrait frame buffer and emits the pixel with its BRAM write address. Tracks frame boundaries and flags malformed frames, so the buffer never receives out-of-range or misaligned writes.

## Interface
Parameters:
- `H_IN`, 320: camera columns per row.
- `V_IN`, 240: camera rows per frame.
- `PIXEL_W`, 16: pixel width.
- `ADDR_W`, 17: address width; must satisfy 2^ADDR_W ≥ H_IN*V_IN.

Ports:
- `clk_in`  in  1  camera-domain clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `valid_pixel_in`  in  1  `pixel_in` valid this cycle.
- `pixel_in`  in  PIXEL_W  camera pixel.
- `frame_done_in`  in  1  single-cycle pulse marking end of a camera frame.
- `pixel_out`  out  PIXEL_W  registered pixel.
- `pixel_addr_out`  out  ADDR_W  frame-buffer write address for `pixel_out`.
- `valid_pixel_out`  out  1  write strobe.
- `frame_done_out`  out  1  one-cycle pulse: a complete, well-formed frame was written.
- `frame_error_out`  out  1  one-cycle pulse: short frame or overflow detected.

## Operation
- Camera coordinates: row r (0..V_IN-1), column c (0..H_IN-1).
- Clockwise mapping:
  - out_x = V_IN-1-r, out_y = c.
  - addr = V_IN*out_y + out_x.
- Address is computed incrementally; no multiplier.
  - Row start: addr = row_base, where row_base starts at V_IN-1.
  - Each accepted pixel within a row: addr += V_IN.
  - After c = H_IN-1: row_base -= 1 and addr = row_base.
- Counters:
  - col, 9 bits, wraps at H_IN-1.
  - row, 8 bits.
  - All arithmetic is unsigned at ADDR_W bits. A well-formed frame never underflows.
- States:
  - SYNC (after reset): discard all pixels. `frame_done_in` → ACTIVE with counters and address cleared to row 0 start.
  - ACTIVE: each `valid_pixel_in` is emitted and advances the counters.
    - Accepting pixel (V_IN-1, H_IN-1) → FULL.
    - `frame_done_in` before the frame is full → pulse `frame_error_out`, reload row 0 start, stay ACTIVE.
  - FULL: `valid_pixel_in` is dropped (no write).
    - The first dropped pixel pulses `frame_error_out` once per frame.
    - `frame_done_in` → pulse `frame_done_out` only if nothing was dropped, then reload row 0 start → ACTIVE.
- If `frame_done_in` and `valid_pixel_in` arrive in the same cycle, `frame_done_in` wins and that pixel is discarded.
- Reset mid-frame: all outputs clear immediately and the state returns to SYNC. The next write occurs only after a subsequent `frame_done_in`.

## Timing
- All outputs are registered; latency is 1 cycle from `valid_pixel_in` to `valid_pixel_out` with matching pixel and address.
- Reset values: `pixel_out`=0, `pixel_addr_out`=0, `valid_pixel_out`=0, `frame_done_out`=0, `frame_error_out`=0, state=SYNC.
- `valid_pixel_out` is asserted only in cycles following an accepted pixel. Back-to-back pixels are sustained at one per cycle.
- `frame_done_out` and `frame_error_out` assert 1 cycle after the triggering `frame_done_in` or the dropped pixel.
- `pixel_out` and `pixel_addr_out` hold their last values while `valid_pixel_out`=0.

## Configuration
- Macro `CAM_ROTATE_WRITER_CCW_EN`.
- Undefined: clockwise mapping as above. First address is V_IN-1, and the address steps +V_IN per pixel.
- Defined: counter-clockwise mapping.
  - out_x = r, out_y = H_IN-1-c.
  - Row start = V_IN*(H_IN-1)+r; the address steps -V_IN per pixel.
  - row_base increments per row.
- Frame tracking and error behaviour are identical in both builds.

## Test plan
- Reset, pixels before any `frame_done_in`, then one `frame_done_in` and 3 pixels: no writes before the pulse; after it, addresses 239, 479, 719, each 1 cycle after input.
- Full 76800-pixel frame then `frame_done_in`:
  - pixel (0,319) → 76799; pixel (1,0) → 238; pixel (239,319) → 76560.
  - `frame_done_out` pulses once; `frame_error_out` stays 0.
- Short frame of 100 pixels, then `frame_done_in`: `frame_error_out` pulses and `frame_done_out` stays 0. The next frame's first address is 239.
- 76802 pixels in one frame: the last 2 are dropped with no `valid_pixel_out`. `frame_error_out` pulses exactly once; `frame_done_out` stays 0 at `frame_done_in`.
- `frame_done_in` coincident with `valid_pixel_in`: that pixel is not written, and the next pixel gets address 239. Separately, assert `rst_in` mid-frame: all outputs are 0 that cycle and no writes occur until the next `frame_done_in`.
- With `CAM_ROTATE_WRITER_CCW_EN`: first three pixels → 76560, 76320, 76080; pixel (1,0) → 76561; pixel (239,319) → 239.
